// File: rtl/apb_master_param.sv
// -----------------------------------------------------------------------------
// apb_master_param
//   Parametrised APB master. Takes read/write commands from a CPU-side
//   valid/ready port and runs APB transfers to one of NUM_SLAVES slaves.
//   Supports read data capture, PSLVERR reporting, back-to-back transfers with
//   no IDLE gap, and an optional wait-state timeout.
//   The PRDATA mux that selects the addressed slave lives outside this block.
//
// Optional feature macro:
//   APB_TIMEOUT_EN  when defined, an ACCESS phase that sees PREADY=0 for
//                   TIMEOUT_CYC cycles is aborted and reported as an error.
//                   When undefined, ACCESS waits indefinitely for PREADY.
//
// Ports:
//   clk        in   1           clock, rising edge
//   PRESET     in   1           asynchronous active-low reset
//   cmd_valid  in   1           command request
//   cmd_ready  out  1           command accepted when cmd_valid && cmd_ready
//   cmd_write  in   1           1 = write, 0 = read
//   cmd_sel    in   SEL_W       slave index (>= NUM_SLAVES is an error)
//   cmd_addr   in   ADDR_W      transfer address
//   cmd_wdata  in   DATA_W      write data
//   rsp_valid  out  1           one-cycle completion pulse
//   rsp_rdata  out  DATA_W      read data (0 for writes / errors)
//   rsp_err    out  1           PSLVERR, invalid select or timeout
//   PSEL       out  NUM_SLAVES  one-hot slave select
//   PENABLE    out  1           access phase
//   PADDR      out  ADDR_W      address
//   PWRITE     out  1           direction
//   PWDATA     out  DATA_W      write data
//   PRDATA     in   DATA_W      selected slave read data
//   PREADY     in   1           slave ready
//   PSLVERR    in   1           slave error, sampled with PENABLE && PREADY
// -----------------------------------------------------------------------------
module apb_master_param #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int NUM_SLAVES  = 4,
   parameter int SEL_W       = ($clog2(NUM_SLAVES) > 0) ? $clog2(NUM_SLAVES) : 1,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                  clk,
   input  logic                  PRESET,
   // command side
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [SEL_W-1:0]      cmd_sel,
   input  logic [ADDR_W-1:0]     cmd_addr,
   input  logic [DATA_W-1:0]     cmd_wdata,
   // response side
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  rsp_err,
   // APB side
   output logic [NUM_SLAVES-1:0] PSEL,
   output logic                  PENABLE,
   output logic [ADDR_W-1:0]     PADDR,
   output logic                  PWRITE,
   output logic [DATA_W-1:0]     PWDATA,
   input  logic [DATA_W-1:0]     PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETUP  = 2'd1,
      S_ACCESS = 2'd2
   } state_e;

   state_e                state_q;
   logic [NUM_SLAVES-1:0] psel_q;
   logic                  penable_q;
   logic [ADDR_W-1:0]     paddr_q;
   logic                  pwrite_q;
   logic [DATA_W-1:0]     pwdata_q;
   logic                  rsp_valid_q;
   logic [DATA_W-1:0]     rsp_rdata_q;
   logic                  rsp_err_q;

   logic [NUM_SLAVES-1:0] sel_onehot;
   logic                  sel_ok;
   logic                  accept;
   logic                  load;

   // One-hot decode of cmd_sel. An index outside 0..NUM_SLAVES-1 decodes to
   // all zeros, which doubles as the invalid-select flag.
   for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_dec
      assign sel_onehot[g] = (cmd_sel == SEL_W'(g));
   end
   assign sel_ok = |sel_onehot;

   // An invalid select is only taken from IDLE: in the completing ACCESS cycle
   // the port stalls it, so it is picked up in the IDLE cycle that follows.
   // PRESET gating keeps ready low while reset holds the FSM in IDLE.
   assign cmd_ready = PRESET &
                      ((state_q == S_IDLE) |
                       ((state_q == S_ACCESS) & PREADY & sel_ok));
   assign accept    = cmd_valid & cmd_ready;
   assign load      = accept & sel_ok;

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   logic [CNT_W-1:0] wcnt_q;
`else
   // TIMEOUT_CYC has no effect in this build.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

   always_ff @(posedge clk or negedge PRESET) begin
      if (!PRESET) begin
         state_q     <= S_IDLE;
         psel_q      <= '0;
         penable_q   <= 1'b0;
         paddr_q     <= '0;
         pwrite_q    <= 1'b0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
         wcnt_q      <= '0;
`endif
      end else begin
         rsp_valid_q <= 1'b0;

         // Transfer attributes are captured on every valid accept and then
         // held through SETUP/ACCESS and any following IDLE.
         if (load) begin
            paddr_q  <= cmd_addr;
            pwrite_q <= cmd_write;
            pwdata_q <= cmd_wdata;
`ifdef APB_TIMEOUT_EN
            wcnt_q   <= '0;
`endif
         end

         case (state_q)
            S_IDLE: begin
               if (load) begin
                  state_q <= S_SETUP;
                  psel_q  <= sel_onehot;
               end else if (accept) begin
                  // Invalid select: no bus activity, immediate error response.
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
               end
            end

            S_SETUP: begin
               state_q   <= S_ACCESS;
               penable_q <= 1'b1;
            end

            S_ACCESS: begin
               if (PREADY) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= PSLVERR;
                  rsp_rdata_q <= (pwrite_q | PSLVERR) ? '0 : PRDATA;
                  penable_q   <= 1'b0;
                  if (load) begin
                     // Back-to-back: straight into the next SETUP.
                     state_q <= S_SETUP;
                     psel_q  <= sel_onehot;
                  end else begin
                     state_q <= S_IDLE;
                     psel_q  <= '0;
                  end
               end
`ifdef APB_TIMEOUT_EN
               else if (wcnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                  // This is the TIMEOUT_CYC-th wait cycle: abort the transfer.
                  state_q     <= S_IDLE;
                  psel_q      <= '0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= '0;
               end else begin
                  wcnt_q <= wcnt_q + 1'b1;
               end
`endif
            end

            default: begin
               state_q   <= S_IDLE;
               psel_q    <= '0;
               penable_q <= 1'b0;
            end
         endcase
      end
   end

   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PADDR     = paddr_q;
   assign PWRITE    = pwrite_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_param.sv
// -----------------------------------------------------------------------------
// tb_apb_master_param
//   Directed bench for apb_master_param (ADDR_W=8, DATA_W=32, NUM_SLAVES=4,
//   SEL_W widened to 3 so out-of-range selects can be driven).
//   Inputs change 1 time unit after the rising edge; outputs are sampled on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_apb_master_param;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 32;
   localparam int NS     = 4;
   localparam int SEL_W  = 3;

   logic              clk;
   logic              PRESET;
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [SEL_W-1:0]  cmd_sel;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [NS-1:0]     PSEL;
   logic              PENABLE;
   logic [ADDR_W-1:0] PADDR;
   logic              PWRITE;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY;
   logic              PSLVERR;

   int n_cmp = 0;
   int n_err = 0;

   apb_master_param #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NS), .SEL_W(SEL_W),
      .TIMEOUT_CYC(16)
   ) dut (
      .clk(clk), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic drv(input logic w, input logic [SEL_W-1:0] s,
                      input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_sel   = s;
      cmd_addr  = a;
      cmd_wdata = d;
   endtask

   // Hard stop in case something wedges the main sequence.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      int  acc;
      int  lat;
      logic seen;

      PRESET = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_sel = '0;
      cmd_addr = '0; cmd_wdata = '0; PRDATA = 32'hDEADBEEF; PREADY = 1'b1;
      PSLVERR = 1'b0;

      // ---- reset state ----
      #3;
      chk("rst_psel",    PSEL,      0);
      chk("rst_penable", PENABLE,   0);
      chk("rst_ready",   cmd_ready, 0);
      chk("rst_rspv",    rsp_valid, 0);
      chk("rst_paddr",   PADDR,     0);
      #9 PRESET = 1'b1;
      #1 chk("idle_ready", cmd_ready, 1);

      // ---- 1: write sel=2, no wait ----
      tick();
      drv(1'b1, 3'd2, 8'h12, 32'hA);
      tick(); cmd_valid = 1'b0;
      smp();
      chk("t1_setup_psel",   PSEL,    4'b0100);
      chk("t1_setup_pen",    PENABLE, 0);
      chk("t1_setup_paddr",  PADDR,   8'h12);
      chk("t1_setup_pwrite", PWRITE,  1);
      chk("t1_setup_pwdata", PWDATA,  32'hA);
      chk("t1_setup_ready",  cmd_ready, 0);
      tick(); smp();
      chk("t1_acc_pen",  PENABLE, 1);
      chk("t1_acc_psel", PSEL,    4'b0100);
      chk("t1_acc_rspv", rsp_valid, 0);
      tick(); smp();
      chk("t1_rspv",  rsp_valid, 1);
      chk("t1_err",   rsp_err,   0);
      chk("t1_rdata", rsp_rdata, 0);
      chk("t1_psel0", PSEL,      0);
      chk("t1_pen0",  PENABLE,   0);
      tick(); smp();
      chk("t1_rspv_pulse", rsp_valid, 0);

      // ---- 2: read sel=0, 3 wait states ----
      tick();
      drv(1'b0, 3'd0, 8'h40, 32'h0);
      PREADY = 1'b0;
      tick(); cmd_valid = 1'b0;
      smp();
      chk("t2_setup_psel", PSEL,    4'b0001);
      chk("t2_setup_pen",  PENABLE, 0);
      n = 0; acc = 0; lat = 0; seen = 1'b0;
      while (n < 20 && !seen) begin
         tick();
         n++;
         if (n == 4) PREADY = 1'b1;
         smp();
         if (rsp_valid) begin
            seen = 1'b1;
            lat  = n;
         end else begin
            if (PENABLE) acc++;
            chk("t2_stable_psel",  PSEL,   4'b0001);
            chk("t2_stable_paddr", PADDR,  8'h40);
            chk("t2_stable_pwr",   PWRITE, 0);
         end
      end
      chk("t2_seen",    seen,      1);
      chk("t2_latency", lat,       5);
      chk("t2_access",  acc,       4);
      chk("t2_rdata",   rsp_rdata, 32'hDEADBEEF);
      chk("t2_err",     rsp_err,   0);

      // ---- 3: back-to-back writes sel=1 then sel=3 ----
      tick();
      drv(1'b1, 3'd1, 8'h21, 32'h11);
      tick();
      drv(1'b1, 3'd3, 8'h23, 32'h33);
      smp();
      chk("t3_setup1_psel", PSEL, 4'b0010);
      tick(); smp();
      chk("t3_acc1_pen",   PENABLE,   1);
      chk("t3_acc1_ready", cmd_ready, 1);
      tick(); cmd_valid = 1'b0;
      smp();
      chk("t3_setup2_psel",  PSEL,      4'b1000);
      chk("t3_setup2_pen",   PENABLE,   0);
      chk("t3_setup2_paddr", PADDR,     8'h23);
      chk("t3_rsp1",         rsp_valid, 1);
      tick(); smp();
      chk("t3_acc2_pen",  PENABLE,   1);
      chk("t3_gap_rspv",  rsp_valid, 0);
      tick(); smp();
      chk("t3_rsp2",      rsp_valid, 1);
      chk("t3_rsp2_psel", PSEL,      0);

      // ---- 4: PSLVERR, then invalid select ----
      tick();
      drv(1'b1, 3'd1, 8'h30, 32'h5);
      tick(); cmd_valid = 1'b0;
      tick(); PSLVERR = 1'b1;
      smp();
      chk("t4_acc_pen", PENABLE, 1);
      tick(); PSLVERR = 1'b0;
      drv(1'b0, 3'd5, 8'h77, 32'h0);
      smp();
      chk("t4_slverr_rspv", rsp_valid, 1);
      chk("t4_slverr_err",  rsp_err,   1);
      chk("t4_inv_ready",   cmd_ready, 1);
      tick(); cmd_valid = 1'b0;
      smp();
      chk("t4_inv_rspv",  rsp_valid, 1);
      chk("t4_inv_err",   rsp_err,   1);
      chk("t4_inv_rdata", rsp_rdata, 0);
      chk("t4_inv_psel",  PSEL,      0);
      chk("t4_inv_pen",   PENABLE,   0);
      tick(); smp();
      chk("t4_inv_pulse", rsp_valid, 0);
      chk("t4_inv_psel2", PSEL,      0);

      // ---- 5: reset during a stalled ACCESS ----
      tick();
      drv(1'b1, 3'd2, 8'h66, 32'h66);
      PREADY = 1'b0;
      tick(); cmd_valid = 1'b0;
      tick(); smp();
      chk("t5_acc_pen", PENABLE, 1);
      #2 PRESET = 1'b0;
      #1;
      chk("t5_rst_psel",  PSEL,      0);
      chk("t5_rst_pen",   PENABLE,   0);
      chk("t5_rst_ready", cmd_ready, 0);
      chk("t5_rst_paddr", PADDR,     0);
      tick(); tick(); smp();
      chk("t5_rst_rspv", rsp_valid, 0);
      #2 PRESET = 1'b1; PREADY = 1'b1;
      tick(); smp();
      chk("t5_post_rspv", rsp_valid, 0);
      tick();
      drv(1'b1, 3'd3, 8'h55, 32'h55);
      tick(); cmd_valid = 1'b0;
      smp();
      chk("t5_post_psel", PSEL, 4'b1000);
      tick(); smp();
      chk("t5_post_pen", PENABLE, 1);
      tick(); smp();
      chk("t5_post_rsp", rsp_valid, 1);
      chk("t5_post_err", rsp_err,   0);

      // ---- 6: PREADY held low ----
      tick();
      drv(1'b1, 3'd0, 8'h01, 32'h1);
      PREADY = 1'b0;
      tick(); cmd_valid = 1'b0;
      n = 0; acc = 0; seen = 1'b0;
`ifdef APB_TIMEOUT_EN
      while (n < 40 && !seen) begin
         tick();
         n++;
         smp();
         if (rsp_valid) seen = 1'b1;
         else if (PENABLE) acc++;
      end
      chk("t6_to_seen",  seen,      1);
      chk("t6_to_acc",   acc,       16);
      chk("t6_to_err",   rsp_err,   1);
      chk("t6_to_rdata", rsp_rdata, 0);
      chk("t6_to_psel",  PSEL,      0);
      chk("t6_to_pen",   PENABLE,   0);
      PREADY = 1'b1;
`else
      while (n < 110) begin
         tick();
         n++;
         smp();
         if (PENABLE && !rsp_valid) acc++;
      end
      chk("t6_hold_acc", acc, 110);
      tick(); PREADY = 1'b1;
      tick(); smp();
      chk("t6_release_rspv", rsp_valid, 1);
      chk("t6_release_err",  rsp_err,   0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
